mfp_debouncer_multi: RTL and testbench

MFP_DEBOUNCER_MULTI -- requirements
Module: mfp_debouncer_multi

---
 rtl/mfp_debouncer_multi.sv | 95 +++++++++
 tb/tb_mfp_debouncer_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mfp_debouncer_multi.sv
// Multi-channel debouncer: two-flop synchronizer, tick-gated stability counter
// per channel, registered edge pulses and an optional long-press detector.
module mfp_debouncer_multi #(
    parameter int               WIDTH      = 1,
    parameter int               DEPTH      = 8,
    parameter int               THRESHOLD  = 2**DEPTH-1,
    parameter int               HOLD_TICKS = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] hold,
    output logic             any_change
);

    localparam logic [DEPTH-1:0] CNT_LAST = DEPTH'(THRESHOLD - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] upd;
    logic [DEPTH-1:0] cntr     [WIDTH];
    logic [DEPTH-1:0] cntr_nxt [WIDTH];

    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            upd[i]      = 1'b0;
            cntr_nxt[i] = cntr[i];
            if (s[i] == out[i]) begin
                cntr_nxt[i] = '0;
            end else if (tick) begin
                if (cntr[i] == CNT_LAST) begin
                    upd[i]      = 1'b1;
                    cntr_nxt[i] = '0;
                end else begin
                    cntr_nxt[i] = cntr[i] + DEPTH'(1);
                end
            end
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1      <= RESET_VAL;
            s          <= RESET_VAL;
            out        <= RESET_VAL;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cntr[i] <= '0;
        end else begin
            sync1      <= in;
            s          <= sync1;
            out        <= out ^ upd;
            rise       <= upd & s;
            fall       <= upd & ~s;
            any_change <= |upd;
            for (int i = 0; i < WIDTH; i++) cntr[i] <= cntr_nxt[i];
        end
    end

    // Long-press: count ticks while the debounced level is high, pulse once on saturation.
    if (HOLD_TICKS > 0) begin : g_hold
        localparam int            HW       = $clog2(HOLD_TICKS + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

        logic [HW-1:0] hcnt [WIDTH];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                hold <= '0;
                for (int i = 0; i < WIDTH; i++) hcnt[i] <= '0;
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    hold[i] <= 1'b0;
                    if (!out[i]) begin
                        hcnt[i] <= '0;
                    end else if (tick && hcnt[i] < HOLD_MAX) begin
                        hcnt[i] <= hcnt[i] + HW'(1);
                        hold[i] <= (hcnt[i] == HOLD_MAX - HW'(1));
                    end
                end
            end
        end
    end else begin : g_no_hold
        assign hold = '0;
    end

endmodule

// File: tb/tb_mfp_debouncer_multi.sv
// Bench for mfp_debouncer_multi: two instances (reset level 0000 and 1010) checked
// every cycle against a run-length model, plus hand-computed directed checks.
module tb_mfp_debouncer_multi;

    localparam int         W   = 4;
    localparam int         THR = 5;
    localparam int         HT  = 20;
    localparam logic [3:0] RVA = 4'b0000;
    localparam logic [3:0] RVB = 4'b1010;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         tick = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = RVB;
    logic [W-1:0] out_a, rise_a, fall_a, hold_a;
    logic [W-1:0] out_b, rise_b, fall_b, hold_b;
    logic         any_a, any_b;
    logic         cmp_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mfp_debouncer_multi #(.WIDTH(W), .DEPTH(4), .THRESHOLD(THR), .HOLD_TICKS(HT), .RESET_VAL(RVA)) dut_a (
        .clk(clk), .resetn(resetn), .tick(tick), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .hold(hold_a), .any_change(any_a));

    mfp_debouncer_multi #(.WIDTH(W), .DEPTH(4), .THRESHOLD(THR), .HOLD_TICKS(HT), .RESET_VAL(RVB)) dut_b (
        .clk(clk), .resetn(resetn), .tick(tick), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .hold(hold_b), .any_change(any_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Model: per channel, the number of consecutive ticked edges on which the
    // synchronized input disagreed with the debounced level; THR of them flip it.
    logic [W-1:0] m_sync1 [2];
    logic [W-1:0] m_s     [2];
    logic [W-1:0] m_out   [2];
    logic [W-1:0] m_rise  [2];
    logic [W-1:0] m_fall  [2];
    logic [W-1:0] m_hold  [2];
    logic         m_any   [2];
    int           m_run   [2][W];
    int           m_hc    [2][W];

    always @(posedge clk or negedge resetn) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                m_sync1[d] = (d == 0) ? RVA : RVB;
                m_s[d]     = m_sync1[d];
                m_out[d]   = m_sync1[d];
                m_rise[d]  = '0;
                m_fall[d]  = '0;
                m_hold[d]  = '0;
                m_any[d]   = 1'b0;
                for (int i = 0; i < W; i++) begin
                    m_run[d][i] = 0;
                    m_hc[d][i]  = 0;
                end
            end else begin
                m_rise[d] = '0;
                m_fall[d] = '0;
                m_hold[d] = '0;
                for (int i = 0; i < W; i++) begin
                    if (!m_out[d][i]) m_hc[d][i] = 0;
                    else if (tick && m_hc[d][i] < HT) begin
                        m_hc[d][i]++;
                        if (m_hc[d][i] == HT) m_hold[d][i] = 1'b1;
                    end
                end
                for (int i = 0; i < W; i++) begin
                    if (m_s[d][i] == m_out[d][i]) m_run[d][i] = 0;
                    else if (tick) begin
                        m_run[d][i]++;
                        if (m_run[d][i] == THR) begin
                            m_run[d][i] = 0;
                            m_out[d][i] = m_s[d][i];
                            if (m_s[d][i]) m_rise[d][i] = 1'b1;
                            else           m_fall[d][i] = 1'b1;
                        end
                    end
                end
                m_any[d]   = |(m_rise[d] | m_fall[d]);
                m_s[d]     = m_sync1[d];
                m_sync1[d] = (d == 0) ? in_a : in_b;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_a", {15'd0, out_a, rise_a, fall_a, hold_a, any_a},
                  {15'd0, m_out[0], m_rise[0], m_fall[0], m_hold[0], m_any[0]});
            check("cycle_b", {15'd0, out_b, rise_b, fall_b, hold_b, any_b},
                  {15'd0, m_out[1], m_rise[1], m_fall[1], m_hold[1], m_any[1]});
        end
    end

    initial begin
        logic flag;

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_out_a", 32'(out_a), 32'(4'b0000));
        check("rst_out_b", 32'(out_b), 32'(4'b1010));
        check("rst_pulses", 32'({rise_a, fall_a, hold_a, any_a, rise_b, fall_b, hold_b, any_b}), 32'd0);
        #2 resetn = 1'b1;
        tick = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press on ch0: new level visible after the 7th edge.
        in_a[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("press_e6", 32'({out_a[0], rise_a[0]}), 32'd0);
        @(negedge clk);
        check("press_e7", 32'({out_a[0], rise_a, fall_a, hold_a}), 32'({1'b1, 4'b0001, 4'b0000, 4'b0000}));
        @(negedge clk);
        check("press_e8", 32'(rise_a), 32'd0);
        in_a[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Bounce on ch1: toggles every 3 cycles never reach the threshold.
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k < 30 && k % 3 == 0) in_a[1] = ~in_a[1];
            @(negedge clk);
            if (rise_a[1] || fall_a[1] || any_a) flag = 1'b1;
        end
        check("bounce_pulses", 32'(flag), 32'd0);
        check("bounce_out", 32'(out_a[1]), 32'd0);

        // Tick gating on ch2: ticks on edges 4,8,..; 5th ticked mismatch edge is 20.
        in_a[2] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick = (k % 4 == 0);
            @(negedge clk);
            if (k == 19) check("gate_e19", 32'(out_a[2]), 32'd0);
            if (k == 20) check("gate_e20", 32'({out_a[2], rise_a[2]}), 32'd3);
        end
        tick = 1'b1;
        in_a[2] = 1'b0;
        repeat (10) @(negedge clk);

        // Long press on ch3, release, second press.
        in_a[3] = 1'b1;
        repeat (7) @(negedge clk);
        check("lp_rise", 32'({out_a[3], rise_a[3]}), 32'd3);
        repeat (19) @(negedge clk);
        check("lp_hold_e19", 32'(hold_a[3]), 32'd0);
        @(negedge clk);
        check("lp_hold_e20", 32'(hold_a), 32'(4'b1000));
        @(negedge clk);
        check("lp_hold_e21", 32'(hold_a[3]), 32'd0);
        repeat (14) @(negedge clk);
        in_a[3] = 1'b0;
        repeat (7) @(negedge clk);
        check("lp_fall", 32'({out_a[3], fall_a[3]}), 32'd1);
        @(negedge clk);
        in_a[3] = 1'b1;
        repeat (27) @(negedge clk);
        check("lp_hold2", 32'(hold_a[3]), 32'd1);
        in_a[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Simultaneous rise on ch0 and fall on ch3 (instance b starts at 1010).
        in_b = 4'b0011;
        repeat (6) @(negedge clk);
        check("sim_e6", 32'({rise_b, fall_b, any_b}), 32'd0);
        @(negedge clk);
        check("sim_rise", 32'(rise_b), 32'(4'b0001));
        check("sim_fall", 32'(fall_b), 32'(4'b1000));
        check("sim_any", 32'(any_b), 32'd1);
        @(negedge clk);
        check("sim_any_off", 32'(any_b), 32'd0);
        check("sim_out", 32'(out_b), 32'(4'b0011));

        // Reset while ch0 of instance b has counted 3 ticks toward a fall.
        in_b = 4'b0010;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_out_b", 32'(out_b), 32'(4'b1010));
        check("rst_mid_pulses", 32'({rise_b, fall_b, hold_b, any_b}), 32'd0);
        in_b = RVB;
        in_a = RVA;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        flag = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (|{rise_b, fall_b, any_b}) flag = 1'b1;
        end
        check("post_rst_quiet", 32'(flag), 32'd0);
        check("post_rst_out_b", 32'(out_b), 32'(4'b1010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
